// File: rtl/hotel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hotel_pkg
// Description : Shared types and constants for the hotel booking datapath:
//               controller state encoding, room count, room base rates,
//               extras surcharges and the "no room" index.
// Revision    : 1.0 - initial release
// ============================================================================
package hotel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALLOC = 2'd1,
        ST_MUL   = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam int NUM_ROOMS = 7;

    // Nightly base rates by room class
    localparam int RATE_ROOM_LARGE = 700;   // idx 0,1 (room1, room2)
    localparam int RATE_ROOM_STD   = 400;   // idx 2..5 (room3_x, room4_x)
    localparam int RATE_ROOM_SUITE = 500;   // idx 6 (room5)

    // Nightly surcharges for extras
    localparam int EXTRA_AC   = 200;
    localparam int EXTRA_WIFI = 100;

    localparam logic [2:0] NO_ROOM = 3'd7;

endpackage : hotel_pkg
`default_nettype wire

// File: rtl/room_slot_finder.sv
`default_nettype none
// ============================================================================
// Module      : room_slot_finder
// Description : Combinational room search. Reports the lowest-index vacant
//               room and the room currently held by a given customer ID.
// Ports       : occupied    - per-room occupied flags
//               room_id     - packed occupant IDs, slot i at [i*ID_W +: ID_W]
//               req_id      - customer ID to look up
//               free_idx    - lowest vacant index (NO_ROOM if none)
//               free_found  - a vacant room exists
//               match_idx   - index of the room held by req_id (NO_ROOM if none)
//               match_found - req_id currently occupies a room
// Revision    : 1.0 - initial release
// ============================================================================
module room_slot_finder
    import hotel_pkg::*;
#(
    parameter int NUM_ROOMS = 7,
    parameter int ID_W      = 4
) (
    input  logic [NUM_ROOMS-1:0]      occupied,
    input  logic [NUM_ROOMS*ID_W-1:0] room_id,
    input  logic [ID_W-1:0]           req_id,
    output logic [2:0]                free_idx,
    output logic                      free_found,
    output logic [2:0]                match_idx,
    output logic                      match_found
);

    // Scan from the top down so the lowest qualifying index is the last
    // assignment and therefore wins.
    always_comb begin
        free_idx    = NO_ROOM;
        free_found  = 1'b0;
        match_idx   = NO_ROOM;
        match_found = 1'b0;
        for (int i = NUM_ROOMS - 1; i >= 0; i--) begin
            if (!occupied[i]) begin
                free_idx   = 3'(i);
                free_found = 1'b1;
            end
            if (occupied[i] && (room_id[i*ID_W +: ID_W] == req_id)) begin
                match_idx   = 3'(i);
                match_found = 1'b1;
            end
        end
    end

endmodule : room_slot_finder
`default_nettype wire

// File: rtl/room_booking_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : room_booking_ctrl
// Description : Booking/checkout sequencing controller. Accepts one request at
//               a time over valid/ready, allocates or releases a room from the
//               seven-room pool, computes the bill with a 3-step shift-add
//               over the day count and returns one response per request.
// Ports       : clk, rst_n (async, active-low)
//               req_valid/req_ready, req_checkout, req_id, req_ac, req_wifi,
//               req_days                         - request channel
//               rsp_valid/rsp_ready, rsp_ok, rsp_room, bill - response channel
//               occupied, room_id                - room occupancy state
// Revision    : 1.0 - initial release
// ============================================================================
module room_booking_ctrl
    import hotel_pkg::*;
#(
    parameter int ID_W      = 4,
    parameter int BILL_W    = 16,
    parameter int NUM_ROOMS = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_checkout,
    input  logic [ID_W-1:0]           req_id,
    input  logic                      req_ac,
    input  logic                      req_wifi,
    input  logic [2:0]                req_days,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_ok,
    output logic [2:0]                rsp_room,
    output logic [BILL_W-1:0]         bill,
    output logic [NUM_ROOMS-1:0]      occupied,
    output logic [NUM_ROOMS*ID_W-1:0] room_id
);

    state_t                      r_state;
    state_t                      w_state_nxt;

    logic                        r_checkout;
    logic [ID_W-1:0]             r_id;
    logic                        r_ac;
    logic                        r_wifi;
    logic [2:0]                  r_days;

    logic [BILL_W-1:0]           r_rate;
    logic [BILL_W-1:0]           r_acc;
    logic [1:0]                  r_step;
    logic [2:0]                  r_slot;

    logic                        r_rsp_valid;
    logic                        r_ok;
    logic [2:0]                  r_room;
    logic [BILL_W-1:0]           r_bill;
    logic [NUM_ROOMS-1:0]        r_occ;
    logic [NUM_ROOMS*ID_W-1:0]   r_room_id;

    logic [2:0]                  w_free_idx;
    logic                        w_free_found;
    logic [2:0]                  w_match_idx;
    logic                        w_match_found;
    logic                        w_book_reject;
    logic [BILL_W-1:0]           w_base;
    logic [BILL_W-1:0]           w_rate;
    logic [BILL_W-1:0]           w_addend;
    logic [BILL_W-1:0]           w_acc_nxt;

    room_slot_finder #(
        .NUM_ROOMS (NUM_ROOMS),
        .ID_W      (ID_W)
    ) u_finder (
        .occupied    (r_occ),
        .room_id     (r_room_id),
        .req_id      (r_id),
        .free_idx    (w_free_idx),
        .free_found  (w_free_found),
        .match_idx   (w_match_idx),
        .match_found (w_match_found)
    );

    // ID 0 marks a vacant slot, so it can never be a valid customer.
    assign w_book_reject = (r_id == '0) || (r_days == 3'd0) ||
                           w_match_found || !w_free_found;

    always_comb begin
        w_base = BILL_W'(RATE_ROOM_STD);
        if (w_free_idx <= 3'd1) begin
            w_base = BILL_W'(RATE_ROOM_LARGE);
        end else if (w_free_idx == 3'd6) begin
            w_base = BILL_W'(RATE_ROOM_SUITE);
        end
    end

    assign w_rate = w_base
                  + (r_ac   ? BILL_W'(EXTRA_AC)   : '0)
                  + (r_wifi ? BILL_W'(EXTRA_WIFI) : '0);

    // One bit of the day count per MUL cycle: bit k contributes rate<<k.
    assign w_addend  = r_days[r_step] ? (r_rate << r_step) : '0;
    assign w_acc_nxt = r_acc + w_addend;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = ST_ALLOC;
                end
            end
            ST_ALLOC: begin
                if (!r_checkout && !w_book_reject) begin
                    w_state_nxt = ST_MUL;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_MUL: begin
                if (r_step == 2'd2) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (r_rsp_valid && rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_checkout  <= 1'b0;
            r_id        <= '0;
            r_ac        <= 1'b0;
            r_wifi      <= 1'b0;
            r_days      <= 3'd0;
            r_rate      <= '0;
            r_acc       <= '0;
            r_step      <= 2'd0;
            r_slot      <= 3'd0;
            r_rsp_valid <= 1'b0;
            r_ok        <= 1'b0;
            r_room      <= 3'd0;
            r_bill      <= '0;
            r_occ       <= '0;
            r_room_id   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_rsp_valid <= 1'b0;
                    if (req_valid) begin
                        r_checkout <= req_checkout;
                        r_id       <= req_id;
                        r_ac       <= req_ac;
                        r_wifi     <= req_wifi;
                        r_days     <= req_days;
                    end
                end
                ST_ALLOC: begin
                    if (r_checkout) begin
                        r_bill <= '0;
                        if (w_match_found) begin
                            r_occ[w_match_idx]                  <= 1'b0;
                            r_room_id[w_match_idx*ID_W +: ID_W] <= '0;
                            r_ok                                <= 1'b1;
                            r_room                              <= w_match_idx;
                        end else begin
                            r_ok   <= 1'b0;
                            r_room <= NO_ROOM;
                        end
                    end else if (w_book_reject) begin
                        r_ok   <= 1'b0;
                        r_room <= NO_ROOM;
                        r_bill <= '0;
                    end else begin
                        r_occ[w_free_idx]                  <= 1'b1;
                        r_room_id[w_free_idx*ID_W +: ID_W] <= r_id;
                        r_slot                             <= w_free_idx;
                        r_rate                             <= w_rate;
                        r_acc                              <= '0;
                        r_step                             <= 2'd0;
                    end
                end
                ST_MUL: begin
                    r_acc  <= w_acc_nxt;
                    r_step <= r_step + 2'd1;
                    if (r_step == 2'd2) begin
                        r_bill <= w_acc_nxt;
                        r_ok   <= 1'b1;
                        r_room <= r_slot;
                    end
                end
                ST_RESP: begin
                    // Response outputs settle on RESP entry; valid rises one
                    // cycle later and drops with the handshake.
                    if (r_rsp_valid && rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end else begin
                        r_rsp_valid <= 1'b1;
                    end
                end
                default: r_rsp_valid <= 1'b0;
            endcase
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_ok    = r_ok;
    assign rsp_room  = r_room;
    assign bill      = r_bill;
    assign occupied  = r_occ;
    assign room_id   = r_room_id;

endmodule : room_booking_ctrl
`default_nettype wire

// File: tb/tb_room_booking_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_room_booking_ctrl
// Description : Self-checking bench for room_booking_ctrl. Table of request
//               records with expected responses, scoreboard queue of
//               expected responses, plus stall and mid-operation reset cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_room_booking_ctrl;

    localparam int ID_W      = 4;
    localparam int BILL_W    = 16;
    localparam int NUM_ROOMS = 7;

    logic                      clk;
    logic                      rst_n;
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_checkout;
    logic [ID_W-1:0]           req_id;
    logic                      req_ac;
    logic                      req_wifi;
    logic [2:0]                req_days;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic                      rsp_ok;
    logic [2:0]                rsp_room;
    logic [BILL_W-1:0]         bill;
    logic [NUM_ROOMS-1:0]      occupied;
    logic [NUM_ROOMS*ID_W-1:0] room_id;

    room_booking_ctrl #(
        .ID_W      (ID_W),
        .BILL_W    (BILL_W),
        .NUM_ROOMS (NUM_ROOMS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_checkout (req_checkout),
        .req_id       (req_id),
        .req_ac       (req_ac),
        .req_wifi     (req_wifi),
        .req_days     (req_days),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_ok       (rsp_ok),
        .rsp_room     (rsp_room),
        .bill         (bill),
        .occupied     (occupied),
        .room_id      (room_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        checkout;
        logic [3:0]  id;
        logic        ac;
        logic        wifi;
        logic [2:0]  days;
        logic        ok;
        logic [2:0]  room;
        logic [15:0] bill;
        int          lat;
        logic [6:0]  occ;
    } vec_t;

    typedef struct {
        logic        ok;
        logic [2:0]  room;
        logic [15:0] bill;
        int          lat;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    logic [3:0]  m_ids[NUM_ROOMS];
    int          n_tests;
    int          n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic co, input logic [3:0] id, input logic ac, input logic wf,
                       input logic [2:0] d, input logic ok, input logic [2:0] rm,
                       input int bl, input int lat, input logic [6:0] occ);
        vec_t v;
        v.checkout = co; v.id = id; v.ac = ac; v.wifi = wf; v.days = d;
        v.ok = ok; v.room = rm; v.bill = 16'(bl); v.lat = lat; v.occ = occ;
        vecs.push_back(v);
    endtask

    function automatic logic [NUM_ROOMS*ID_W-1:0] packed_ids();
        logic [NUM_ROOMS*ID_W-1:0] p;
        p = '0;
        for (int i = 0; i < NUM_ROOMS; i++) p[i*ID_W +: ID_W] = m_ids[i];
        return p;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        check({tag, "_rsp_ok"},    32'(rsp_ok),    0);
        check({tag, "_rsp_room"},  32'(rsp_room),  0);
        check({tag, "_bill"},      32'(bill),      0);
        check({tag, "_occupied"},  32'(occupied),  0);
        check({tag, "_room_id"},   32'(room_id),   0);
        check({tag, "_req_ready"}, 32'(req_ready), 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NUM_ROOMS; i++) m_ids[i] = '0;
    endtask

    // Issue one request, wait for its response, optionally stall it.
    task automatic run_req(input vec_t v, input int stall);
        exp_t e;
        int   lat;
        @(negedge clk);
        req_checkout = v.checkout; req_id = v.id; req_ac = v.ac;
        req_wifi = v.wifi; req_days = v.days; req_valid = 1'b1;
        check("req_ready_before", 32'(req_ready), 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        sb.push_back('{ok: v.ok, room: v.room, bill: v.bill, lat: v.lat});
        rsp_ready = (stall == 0);
        lat = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) lat = k;
        end
        e = sb.pop_front();
        if (lat == 0) begin
            check("rsp_timeout", 0, 1);
            rsp_ready = 1'b1;
            return;
        end
        check("latency",  32'(lat),      32'(e.lat));
        check("rsp_ok",   32'(rsp_ok),   32'(e.ok));
        check("rsp_room", 32'(rsp_room), 32'(e.room));
        check("bill",     32'(bill),     32'(e.bill));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            check("stall_valid",     32'(rsp_valid), 1);
            check("stall_room",      32'(rsp_room),  32'(e.room));
            check("stall_bill",      32'(bill),      32'(e.bill));
            check("stall_req_ready", 32'(req_ready), 0);
        end
        if (stall != 0) begin
            @(negedge clk);
            rsp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check("post_hs_valid", 32'(rsp_valid), 0);
        check("post_hs_ready", 32'(req_ready), 1);
        if (v.ok && !v.checkout) m_ids[v.room] = v.id;
        if (v.ok && v.checkout)  m_ids[v.room] = '0;
        check("occupied", 32'(occupied), 32'(v.occ));
        check("room_id",  32'(room_id),  32'(packed_ids()));
    endtask

    initial begin
        vec_t v;
        int   lat;
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_checkout = 1'b0; req_id = '0;
        req_ac = 1'b0; req_wifi = 1'b0; req_days = 3'd0; rsp_ready = 1'b1;
        for (int i = 0; i < NUM_ROOMS; i++) m_ids[i] = '0;

        // First scenario: single booking with both extras
        do_reset();
        add(0, 3, 1, 1, 2, 1, 0, 2000, 5, 7'b0000001);
        run_req(vecs.pop_front(), 0);

        do_reset();
        //  co id ac wf d  ok rm bill lat occ
        add(0, 1, 0, 0, 1, 1, 0, 700, 5, 7'b0000001);
        add(0, 2, 0, 0, 1, 1, 1, 700, 5, 7'b0000011);
        add(0, 3, 0, 0, 1, 1, 2, 400, 5, 7'b0000111);
        add(0, 4, 0, 0, 1, 1, 3, 400, 5, 7'b0001111);
        add(0, 5, 0, 0, 1, 1, 4, 400, 5, 7'b0011111);
        add(0, 6, 0, 0, 1, 1, 5, 400, 5, 7'b0111111);
        add(0, 7, 0, 0, 1, 1, 6, 500, 5, 7'b1111111);
        add(0, 8, 0, 0, 1, 0, 7, 0,   2, 7'b1111111);  // pool full
        add(1, 3, 0, 0, 0, 1, 2, 0,   2, 7'b1111011);
        add(0, 9, 0, 1, 7, 1, 2, 3500, 5, 7'b1111111);
        add(1, 5, 0, 0, 0, 1, 4, 0,   2, 7'b1101111);
        add(0, 10, 0, 0, 0, 0, 7, 0,  2, 7'b1101111);  // days = 0
        add(0, 0, 0, 0, 3, 0, 7, 0,   2, 7'b1101111);  // id = 0
        add(0, 1, 0, 0, 2, 0, 7, 0,   2, 7'b1101111);  // duplicate id
        add(1, 12, 0, 0, 0, 0, 7, 0,  2, 7'b1101111);  // unknown checkout
        add(0, 11, 1, 0, 3, 1, 4, 1800, 5, 7'b1111111);
        add(1, 11, 0, 0, 0, 1, 4, 0,  2, 7'b1101111);
        for (int i = 0; vecs.size() > 0; i++) run_req(vecs.pop_front(), 0);

        // Stalled response: room 4 (400/night) for 5 nights
        v = '{checkout: 0, id: 13, ac: 0, wifi: 0, days: 5, ok: 1, room: 4,
              bill: 16'd2000, lat: 5, occ: 7'b1111111};
        run_req(v, 10);

        // Reset during the second MUL cycle
        v = '{checkout: 1, id: 1, ac: 0, wifi: 0, days: 0, ok: 1, room: 0,
              bill: 16'd0, lat: 2, occ: 7'b1111110};
        run_req(v, 0);
        @(negedge clk);
        req_checkout = 1'b0; req_id = 4'd14; req_ac = 1'b0; req_wifi = 1'b0;
        req_days = 3'd3; req_valid = 1'b1;
        @(posedge clk);            // transfer edge T
        #1;
        req_valid = 1'b0;
        @(posedge clk);            // ALLOC edge T+1
        @(posedge clk);            // first MUL edge T+2
        #1;
        check("mid_occ_before_reset", 32'(occupied), 32'(7'b1111111));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) lat = 1;
        end
        check("no_rsp_after_reset", 32'(lat), 0);
        check("occ_after_reset",    32'(occupied), 0);
        check("ready_after_reset",  32'(req_ready), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_room_booking_ctrl
`default_nettype wire
